// File: rtl/scr1_pipe_dmem_arb_pkg.sv
// Shared types for the DMEM arbiter slice.
// Carries the memory-interface types (command, width, response), the bus
// widths, the arbiter FSM encoding and the default watchdog timeout.
package scr1_pipe_dmem_arb_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_ARB_IDLE  = 2'b00,
    SCR1_DMEM_ARB_BUSY  = 2'b01,
    SCR1_DMEM_ARB_DRAIN = 2'b10
  } type_scr1_dmem_arb_fsm_e;

  localparam int SCR1_DMEM_ARB_TIMEOUT_CYC = 256;

endpackage : scr1_pipe_dmem_arb_pkg

// File: rtl/scr1_pipe_dmem_arb_rr.sv
// 2-way round-robin selector.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request lines of port 1 / port 0
//   ack        : the current selection was granted this cycle
//   sel        : selected port (0 or 1)
// last_gnt resets to 1 so that port 0 wins the first tie.
module scr1_dmem_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       ack,
  output logic       sel
);

  logic last_gnt;

  always_comb begin
    sel = ~last_gnt;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last_gnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (ack) begin
      last_gnt <= sel;
    end
  end

endmodule : scr1_dmem_arb_rr

// File: rtl/scr1_pipe_dmem_arb.sv
// Two-requester DMEM arbiter: port 0 (LSU) and port 1 (debug/system master)
// share one DMEM port with a single outstanding transaction.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   p0_* / p1_*           : requester ports (req/cmd/width/addr/wdata in,
//                           req_ack/rdata/resp out)
//   dmem_*                : shared DMEM port toward the router
//   dbg_fsm_o             : current arbiter state, for observation
// Handshake: a request is accepted in the IDLE cycle where req and
// dmem_req_ack_i are both high; the owner's response is the first
// dmem_resp_i != NOTRDY afterwards. Requests must be held until acked.
// A watchdog turns a response that never arrives into RDY_ER toward the
// owner and then silently swallows the late memory response in DRAIN.
module scr1_pipe_dmem_arb
  import scr1_pipe_dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = SCR1_DMEM_ARB_TIMEOUT_CYC,
  parameter int CNT_W       = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        p0_req_i,
  input  type_scr1_mem_cmd_e          p0_cmd_i,
  input  type_scr1_mem_width_e        p0_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] p0_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] p0_wdata_i,
  output logic                        p0_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] p0_rdata_o,
  output type_scr1_mem_resp_e         p0_resp_o,
  input  logic                        p1_req_i,
  input  type_scr1_mem_cmd_e          p1_cmd_i,
  input  type_scr1_mem_width_e        p1_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] p1_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] p1_wdata_i,
  output logic                        p1_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] p1_rdata_o,
  output type_scr1_mem_resp_e         p1_resp_o,
  output logic                        dmem_req_o,
  output type_scr1_mem_cmd_e          dmem_cmd_o,
  output type_scr1_mem_width_e        dmem_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata_o,
  input  logic                        dmem_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata_i,
  input  type_scr1_mem_resp_e         dmem_resp_i,
  output type_scr1_dmem_arb_fsm_e     dbg_fsm_o
);

  localparam bit             WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  type_scr1_dmem_arb_fsm_e fsm, fsm_nxt;
  logic                    owner, owner_nxt;
  logic [CNT_W-1:0]        wd_cnt, wd_nxt;
  logic                    sel;
  logic                    any_req;
  logic                    rr_ack;
  type_scr1_mem_resp_e     resp_fwd;

  assign any_req   = p0_req_i | p1_req_i;
  assign dbg_fsm_o = fsm;

  scr1_dmem_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({p1_req_i, p0_req_i}),
    .ack   (rr_ack),
    .sel   (sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm    <= SCR1_DMEM_ARB_IDLE;
      owner  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      fsm    <= fsm_nxt;
      owner  <= owner_nxt;
      wd_cnt <= wd_nxt;
    end
  end

  always_comb begin
    fsm_nxt      = fsm;
    owner_nxt    = owner;
    wd_nxt       = wd_cnt;
    rr_ack       = 1'b0;
    resp_fwd     = SCR1_MEM_RESP_NOTRDY;
    dmem_req_o   = 1'b0;
    p0_req_ack_o = 1'b0;
    p1_req_ack_o = 1'b0;
    p0_resp_o    = SCR1_MEM_RESP_NOTRDY;
    p1_resp_o    = SCR1_MEM_RESP_NOTRDY;
    p0_rdata_o   = '0;
    p1_rdata_o   = '0;
    // Request fields always follow the selected port; only dmem_req_o
    // qualifies them.
    dmem_cmd_o   = sel ? p1_cmd_i   : p0_cmd_i;
    dmem_width_o = sel ? p1_width_i : p0_width_i;
    dmem_addr_o  = sel ? p1_addr_i  : p0_addr_i;
    dmem_wdata_o = sel ? p1_wdata_i : p0_wdata_i;

    case (fsm)
      SCR1_DMEM_ARB_IDLE: begin
        // Stray responses in IDLE fall through to the NOTRDY defaults.
        dmem_req_o = any_req;
        if (any_req && dmem_req_ack_i) begin
          if (sel) p1_req_ack_o = 1'b1;
          else     p0_req_ack_o = 1'b1;
          rr_ack    = 1'b1;
          owner_nxt = sel;
          wd_nxt    = '0;
          fsm_nxt   = SCR1_DMEM_ARB_BUSY;
        end
      end
      SCR1_DMEM_ARB_BUSY: begin
        resp_fwd = dmem_resp_i;
        // A real response wins over a watchdog expiry in the same cycle.
        if (dmem_resp_i != SCR1_MEM_RESP_NOTRDY) begin
          fsm_nxt = SCR1_DMEM_ARB_IDLE;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          resp_fwd = SCR1_MEM_RESP_RDY_ER;
          fsm_nxt  = SCR1_DMEM_ARB_DRAIN;
        end else begin
          wd_nxt = wd_cnt + CNT_W'(1);
        end
        if (owner) begin
          p1_resp_o  = resp_fwd;
          p1_rdata_o = dmem_rdata_i;
        end else begin
          p0_resp_o  = resp_fwd;
          p0_rdata_o = dmem_rdata_i;
        end
      end
      SCR1_DMEM_ARB_DRAIN: begin
        // The late response belongs to an already-failed transaction.
        if (dmem_resp_i != SCR1_MEM_RESP_NOTRDY) begin
          fsm_nxt = SCR1_DMEM_ARB_IDLE;
        end
      end
      default: begin
        fsm_nxt = SCR1_DMEM_ARB_IDLE;
      end
    endcase
  end

endmodule : scr1_pipe_dmem_arb

// File: tb/tb_scr1_pipe_dmem_arb.sv
module tb_scr1_pipe_dmem_arb;
  import scr1_pipe_dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                        p0_req, p1_req;
  type_scr1_mem_cmd_e          p0_cmd, p1_cmd;
  type_scr1_mem_width_e        p0_width, p1_width;
  logic [SCR1_DMEM_AWIDTH-1:0] p0_addr, p1_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] p0_wdata, p1_wdata;
  logic                        p0_ack, p1_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] p0_rdata, p1_rdata;
  type_scr1_mem_resp_e         p0_resp, p1_resp;
  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_width_e        dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
  logic                        dmem_req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;
  type_scr1_dmem_arb_fsm_e     dbg_fsm;

  scr1_pipe_dmem_arb #(.TIMEOUT_CYC(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0_req_i       (p0_req),
    .p0_cmd_i       (p0_cmd),
    .p0_width_i     (p0_width),
    .p0_addr_i      (p0_addr),
    .p0_wdata_i     (p0_wdata),
    .p0_req_ack_o   (p0_ack),
    .p0_rdata_o     (p0_rdata),
    .p0_resp_o      (p0_resp),
    .p1_req_i       (p1_req),
    .p1_cmd_i       (p1_cmd),
    .p1_width_i     (p1_width),
    .p1_addr_i      (p1_addr),
    .p1_wdata_i     (p1_wdata),
    .p1_req_ack_o   (p1_ack),
    .p1_rdata_o     (p1_rdata),
    .p1_resp_o      (p1_resp),
    .dmem_req_o     (dmem_req),
    .dmem_cmd_o     (dmem_cmd),
    .dmem_width_o   (dmem_width),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_req_ack_i (dmem_req_ack),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_resp_i    (dmem_resp),
    .dbg_fsm_o      (dbg_fsm)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked
  // one more unit later, well before the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p1_req = 1'b0;
    p0_cmd = SCR1_MEM_CMD_RD; p1_cmd = SCR1_MEM_CMD_RD;
    p0_width = SCR1_MEM_WIDTH_WORD; p1_width = SCR1_MEM_WIDTH_WORD;
    p0_addr = 32'h0000_0100; p1_addr = 32'h0000_0200;
    p0_wdata = '0; p1_wdata = '0;
    dmem_req_ack = 1'b0;
    dmem_rdata = '0;
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    do_reset();
    settle();
    check("rst_fsm", dbg_fsm, SCR1_DMEM_ARB_IDLE);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_p0_resp", p0_resp, SCR1_MEM_RESP_NOTRDY);
    check("rst_p1_resp", p1_resp, SCR1_MEM_RESP_NOTRDY);

    // ---- single p0 read ----
    next_cycle();
    p0_req = 1'b1; p0_addr = 32'h0000_0100; dmem_req_ack = 1'b1;
    settle();
    check("rd_dmem_req", dmem_req, 1);
    check("rd_dmem_addr", dmem_addr, 32'h0000_0100);
    check("rd_p0_ack", p0_ack, 1);
    check("rd_p1_ack", p1_ack, 0);
    next_cycle();
    p0_req = 1'b0; dmem_req_ack = 1'b0;
    settle();
    check("rd_busy_fsm", dbg_fsm, SCR1_DMEM_ARB_BUSY);
    check("rd_busy_req", dmem_req, 0);
    check("rd_busy_p0_resp", p0_resp, SCR1_MEM_RESP_NOTRDY);
    next_cycle();
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'hDEAD_BEEF;
    settle();
    check("rd_p0_resp", p0_resp, SCR1_MEM_RESP_RDY_OK);
    check("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("rd_p1_resp", p1_resp, SCR1_MEM_RESP_NOTRDY);
    check("rd_p1_rdata", p1_rdata, 0);
    next_cycle();
    dmem_resp = SCR1_MEM_RESP_NOTRDY; dmem_rdata = '0;
    settle();
    check("rd_back_idle", dbg_fsm, SCR1_DMEM_ARB_IDLE);

    // ---- continuous requests from both ports, zero-wait memory ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'(i % 2));
    end
    for (int i = 0; i < 4; i++) begin
      logic [63:0] g;
      g = exp_q.pop_front();
      p0_req = 1'b1; p1_req = 1'b1;
      p0_addr = 32'h0000_0010; p1_addr = 32'h0000_0020;
      dmem_req_ack = 1'b1; dmem_resp = SCR1_MEM_RESP_NOTRDY;
      settle();
      check($sformatf("rr%0d_p0_ack", i), p0_ack, (g == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_p1_ack", i), p1_ack, (g == 1) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_addr", i), dmem_addr, (g == 0) ? 64'h10 : 64'h20);
      next_cycle();
      dmem_req_ack = 1'b0; dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'(i + 5);
      settle();
      check($sformatf("rr%0d_own_resp", i), (g == 0) ? p0_resp : p1_resp, SCR1_MEM_RESP_RDY_OK);
      check($sformatf("rr%0d_oth_resp", i), (g == 0) ? p1_resp : p0_resp, SCR1_MEM_RESP_NOTRDY);
      check($sformatf("rr%0d_rdata", i), (g == 0) ? p0_rdata : p1_rdata, 64'(i + 5));
      next_cycle();
    end
    idle_inputs();

    // ---- p1 write while p0 is busy ----
    next_cycle();
    p0_req = 1'b1; dmem_req_ack = 1'b1;
    settle();
    check("wr_p0_ack", p0_ack, 1);
    next_cycle();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_cmd = SCR1_MEM_CMD_WR; p1_addr = 32'h0000_0300;
    p1_wdata = 32'hCAFE_F00D; p1_width = SCR1_MEM_WIDTH_HWORD;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("wr_busy%0d_p1_ack", i), p1_ack, 0);
      check($sformatf("wr_busy%0d_req", i), dmem_req, 0);
      next_cycle();
    end
    dmem_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    check("wr_p0_resp", p0_resp, SCR1_MEM_RESP_RDY_OK);
    check("wr_resp_p1_ack", p1_ack, 0);
    next_cycle();
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    check("wr_p1_ack", p1_ack, 1);
    check("wr_cmd", dmem_cmd, SCR1_MEM_CMD_WR);
    check("wr_width", dmem_width, SCR1_MEM_WIDTH_HWORD);
    check("wr_wdata", dmem_wdata, 32'hCAFE_F00D);
    check("wr_addr", dmem_addr, 32'h0000_0300);
    next_cycle();
    p1_req = 1'b0; dmem_req_ack = 1'b0; dmem_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    check("wr_p1_resp", p1_resp, SCR1_MEM_RESP_RDY_OK);
    next_cycle();
    idle_inputs();

    // ---- watchdog timeout, memory silent ----
    next_cycle();
    p0_req = 1'b1; dmem_req_ack = 1'b1;
    settle();
    check("to_p0_ack", p0_ack, 1);
    next_cycle();
    p0_req = 1'b0; dmem_req_ack = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      check($sformatf("to_wait%0d", i), p0_resp, SCR1_MEM_RESP_NOTRDY);
      next_cycle();
    end
    settle();
    check("to_p0_er", p0_resp, SCR1_MEM_RESP_RDY_ER);
    next_cycle();
    p0_req = 1'b1; dmem_req_ack = 1'b1;
    for (int i = 1; i < 10; i++) begin
      settle();
      check($sformatf("to_drain%0d_fsm", i), dbg_fsm, SCR1_DMEM_ARB_DRAIN);
      check($sformatf("to_drain%0d_ack", i), p0_ack, 0);
      next_cycle();
    end
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h1234_5678;
    settle();
    check("to_late_resp", p0_resp, SCR1_MEM_RESP_NOTRDY);
    check("to_late_ack", p0_ack, 0);
    check("to_late_req", dmem_req, 0);
    next_cycle();
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    check("to_next_ack", p0_ack, 1);
    next_cycle();
    p0_req = 1'b0; dmem_req_ack = 1'b0; dmem_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    check("to_next_resp", p0_resp, SCR1_MEM_RESP_RDY_OK);
    next_cycle();
    idle_inputs();

    // ---- response exactly on the timeout cycle ----
    next_cycle();
    p0_req = 1'b1; dmem_req_ack = 1'b1;
    next_cycle();
    p0_req = 1'b0; dmem_req_ack = 1'b0;
    for (int i = 1; i < 4; i++) next_cycle();
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'h0000_00A5;
    settle();
    check("edge_p0_resp", p0_resp, SCR1_MEM_RESP_RDY_OK);
    check("edge_p0_rdata", p0_rdata, 32'h0000_00A5);
    next_cycle();
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    check("edge_fsm_idle", dbg_fsm, SCR1_DMEM_ARB_IDLE);
    idle_inputs();

    // ---- reset during BUSY; last grant was p0, so only reset lets p0 win ----
    next_cycle();
    p0_req = 1'b1; dmem_req_ack = 1'b1;
    next_cycle();
    p0_req = 1'b0; dmem_req_ack = 1'b0;
    settle();
    check("rb_busy", dbg_fsm, SCR1_DMEM_ARB_BUSY);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    dmem_resp = SCR1_MEM_RESP_RDY_OK;
    settle();
    check("rb_fsm", dbg_fsm, SCR1_DMEM_ARB_IDLE);
    check("rb_stray_p0", p0_resp, SCR1_MEM_RESP_NOTRDY);
    check("rb_stray_p1", p1_resp, SCR1_MEM_RESP_NOTRDY);
    check("rb_req", dmem_req, 0);
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    p0_req = 1'b1; p1_req = 1'b1; dmem_req_ack = 1'b1;
    settle();
    check("rb_tie_p0_ack", p0_ack, 1);
    check("rb_tie_p1_ack", p1_ack, 0);
    check("rb_tie_addr", dmem_addr, 32'h0000_0100);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_scr1_pipe_dmem_arb
